// File: rtl/instr_encoder.sv
// RV32I instruction encoder/loader: packs field-level requests into 32-bit words,
// rejects illegal requests, and streams legal words into instruction memory.
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_class,
    input  logic [2:0]        req_funct3,
    input  logic              req_alt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_OPIMM  = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_LUI    = 3'd5;
    localparam logic [2:0] CLS_JAL    = 3'd6;
    localparam logic [2:0] CLS_JALR   = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] addr_q;

    logic        s1_valid;
    logic [2:0]  s1_class;
    logic [2:0]  s1_funct3;
    logic        s1_alt;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [31:0] s1_imm;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic [6:0]  funct7;
    logic        imm_u11;
    logic        imm_u12;
    logic        imm_u20;
    logic        is_shift;

    logic              s1_adv;
    logic              s1_legal_adv;
    logic              s1_illegal_adv;
    logic              pend_legal;
    logic [ADDR_W:0]   accepted;
    logic              req_fire;
    logic              cnt_hit;

    assign funct7   = s1_alt ? 7'b0100000 : 7'b0000000;
    assign imm_u11  = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
    assign imm_u12  = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
    assign imm_u20  = (&s1_imm[31:20]) || !(|s1_imm[31:20]);
    assign is_shift = (s1_funct3 == 3'b001) || (s1_funct3 == 3'b101);

    // Field packing and legality check for the request held in S1
    always_comb begin
        enc_word    = '0;
        enc_illegal = 1'b0;
        case (s1_class)
            CLS_R: begin
                enc_word    = {funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, OP_R};
                enc_illegal = s1_alt && (s1_funct3 != 3'b000) && (s1_funct3 != 3'b101);
            end
            CLS_OPIMM: begin
                if (is_shift) begin
                    enc_word    = {funct7, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, OP_OPIMM};
                    enc_illegal = (s1_alt && (s1_funct3 != 3'b101)) || (|s1_imm[31:5]);
                end else begin
                    enc_word    = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, OP_OPIMM};
                    enc_illegal = s1_alt || !imm_u11;
                end
            end
            CLS_LOAD: begin
                enc_word    = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, OP_LOAD};
                enc_illegal = (s1_funct3 == 3'b011) || (s1_funct3 == 3'b110) ||
                              (s1_funct3 == 3'b111) || !imm_u11;
            end
            CLS_STORE: begin
                enc_word    = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], OP_STORE};
                enc_illegal = (s1_funct3 > 3'b010) || !imm_u11;
            end
            CLS_BRANCH: begin
                enc_word    = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                               s1_imm[4:1], s1_imm[11], OP_BRANCH};
                enc_illegal = (s1_funct3 == 3'b010) || (s1_funct3 == 3'b011) ||
                              !imm_u12 || s1_imm[0];
            end
            CLS_LUI: begin
                enc_word    = {s1_imm[31:12], s1_rd, OP_LUI};
                enc_illegal = |s1_imm[11:0];
            end
            CLS_JAL: begin
                enc_word    = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, OP_JAL};
                enc_illegal = !imm_u20 || s1_imm[0];
            end
            CLS_JALR: begin
                enc_word    = {s1_imm[11:0], s1_rs1, 3'b000, s1_rd, OP_JALR};
                enc_illegal = (s1_funct3 != 3'b000) || !imm_u11;
            end
            default: begin
                enc_word    = '0;
                enc_illegal = 1'b1;
            end
        endcase
    end

    // A legal word sitting in S1 already counts toward cfg_len so we never over-accept
    assign s1_adv         = s1_valid && (!mem_we || mem_ready);
    assign s1_legal_adv   = s1_adv && !enc_illegal;
    assign s1_illegal_adv = s1_adv && enc_illegal;
    assign pend_legal     = s1_valid && !enc_illegal;
    assign accepted       = {1'b0, cnt_q} + {{ADDR_W{1'b0}}, pend_legal};
    assign req_ready      = (state_q == ST_RUN) && (accepted < {1'b0, len_q}) &&
                            (!s1_valid || s1_adv);
    assign req_fire       = req_valid && req_ready;
    assign cnt_hit        = s1_legal_adv && ((cnt_q + ADDR_W'(1)) == len_q);
    assign busy           = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_hit) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (mem_we && mem_ready) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            err_illegal <= 1'b0;
            err_addr    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && start) begin
                len_q       <= cfg_len;
                addr_q      <= cfg_base;
                cnt_q       <= '0;
                err_illegal <= 1'b0;
                err_addr    <= '0;
            end else begin
                if (s1_legal_adv) begin
                    cnt_q  <= cnt_q + ADDR_W'(1);
                    addr_q <= addr_q + ADDR_W'(1);
                end
                if (s1_illegal_adv) begin
                    err_illegal <= 1'b1;
                    if (!err_illegal) err_addr <= addr_q;
                end
            end
        end
    end

    // S1 request register and S2 output register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_class  <= '0;
            s1_funct3 <= '0;
            s1_alt    <= 1'b0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_imm    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (req_fire) begin
                s1_valid  <= 1'b1;
                s1_class  <= req_class;
                s1_funct3 <= req_funct3;
                s1_alt    <= req_alt;
                s1_rd     <= req_rd;
                s1_rs1    <= req_rs1;
                s1_rs2    <= req_rs2;
                s1_imm    <= req_imm;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_legal_adv) begin
                mem_we    <= 1'b1;
                mem_addr  <= addr_q;
                mem_wdata <= enc_word;
            end else if (mem_ready) begin
                mem_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, corner-case sequences,
// and randomized jobs scored against an arithmetic reference encoder.
module tb_instr_encoder;

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        req_t        req;
        logic [31:0] word;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  cfg_base;
    logic [9:0]  cfg_len;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_class;
    logic [2:0]  req_funct3;
    logic        req_alt;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        mem_we;
    logic        mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err_illegal;
    logic [9:0]  err_addr;

    logic ready_force;
    logic rand_ready;
    logic rnd_bit;

    int n_checks;
    int n_pass;
    int done_cnt;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    vec_t vecs[12];

    instr_encoder #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
        .req_funct3(req_funct3), .req_alt(req_alt), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .err_illegal(err_illegal), .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    assign mem_ready = rand_ready ? rnd_bit : ready_force;

    // Write monitor: a handshake seen at the falling edge commits on the next rising edge
    always @(negedge clk) begin
        if (mem_we && mem_ready) begin
            wr_addr.push_back(32'(mem_addr));
            wr_data.push_back(mem_wdata);
        end
        if (done) done_cnt++;
    end

    function automatic req_t mk(input logic [2:0] cls, input logic [2:0] f3, input logic alt,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm);
        req_t r;
        r.cls = cls; r.f3 = f3; r.alt = alt;
        r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        return r;
    endfunction

    // Reference encoder built from signed ranges and shift/mask arithmetic
    function automatic logic [31:0] model_encode(input req_t r, output bit ok);
        logic [31:0] u;
        logic [31:0] w;
        logic [31:0] itype;
        int s;
        bit r11;
        u = r.imm;
        s = $signed(r.imm);
        r11 = (s >= -2048) && (s <= 2047);
        itype = (32'(r.rs1) << 15) | (32'(r.f3) << 12) | (32'(r.rd) << 7);
        case (r.cls)
            3'd0: begin
                ok = !r.alt || (r.f3 == 3'd0) || (r.f3 == 3'd5);
                w = (r.alt ? 32'h4000_0000 : 32'h0) | (32'(r.rs2) << 20) | itype | 32'd51;
            end
            3'd1: begin
                if ((r.f3 == 3'd1) || (r.f3 == 3'd5)) begin
                    ok = (!r.alt || (r.f3 == 3'd5)) && (u < 32'd32);
                    w = (r.alt ? 32'h4000_0000 : 32'h0) | ((u % 32'd32) << 20) | itype | 32'd19;
                end else begin
                    ok = !r.alt && r11;
                    w = ((u & 32'hFFF) << 20) | itype | 32'd19;
                end
            end
            3'd2: begin
                ok = (r.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && r11;
                w = ((u & 32'hFFF) << 20) | itype | 32'd3;
            end
            3'd3: begin
                ok = (r.f3 <= 3'd2) && r11;
                w = (((u >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) |
                    (32'(r.f3) << 12) | ((u & 32'h1F) << 7) | 32'd35;
            end
            3'd4: begin
                ok = (r.f3 != 3'd2) && (r.f3 != 3'd3) && (s >= -4096) && (s <= 4095) && !u[0];
                w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) |
                    (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) |
                    (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'd99;
            end
            3'd5: begin
                ok = ((u & 32'hFFF) == 32'h0);
                w = (u & 32'hFFFF_F000) | (32'(r.rd) << 7) | 32'd55;
            end
            3'd6: begin
                ok = (s >= -1048576) && (s <= 1048575) && !u[0];
                w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                    (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) |
                    (32'(r.rd) << 7) | 32'd111;
            end
            default: begin
                ok = (r.f3 == 3'd0) && r11;
                w = ((u & 32'hFFF) << 20) | (32'(r.rs1) << 15) | (32'(r.rd) << 7) | 32'd103;
            end
        endcase
        return w;
    endfunction

    function automatic logic [31:0] rand_imm();
        int b[14];
        b = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098, 31, 32,
              1048574, 1048576, -1048576, 0};
        case ($urandom_range(0, 5))
            0, 1, 2: return 32'(int'($urandom_range(0, 80)) - 40);
            3:       return 32'(b[$urandom_range(0, 13)]);
            4:       return $urandom();
            default: return $urandom() & 32'hFFFF_F000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, got, want);
    endtask

    task automatic applyStimulus(input req_t r);
        int n;
        req_class = r.cls; req_funct3 = r.f3; req_alt = r.alt;
        req_rd = r.rd; req_rs1 = r.rs1; req_rs2 = r.rs2; req_imm = r.imm;
        req_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 300) begin
                checkOutput("req_accept_timeout", 32'(req_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic start_job(input logic [9:0] base, input logic [9:0] len);
        cfg_base = base;
        cfg_len = len;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic compare_writes(input string tag);
        checkOutput({tag, "_write_count"}, 32'(wr_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < wr_data.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), wr_addr[i], exp_addr[i]);
            checkOutput($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data[i]);
        end
        wr_addr.delete(); wr_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic run_random_job(input int n);
        req_t        list[$];
        req_t        r;
        bit          ok;
        logic [31:0] w;
        logic [9:0]  base;
        logic [9:0]  a;
        logic [9:0]  first_bad;
        bit          any_bad;
        int          legal;
        for (int i = 0; i < n; i++) begin
            r = mk(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   ($urandom_range(0, 7) == 0), 5'($urandom), 5'($urandom), 5'($urandom),
                   rand_imm());
            list.push_back(r);
        end
        list.push_back(mk(3'd0, 3'd0, 1'b0, 5'($urandom), 5'($urandom), 5'($urandom), 32'h0));
        base = 10'($urandom_range(0, 1023));
        a = base;
        legal = 0;
        any_bad = 1'b0;
        first_bad = '0;
        foreach (list[i]) begin
            w = model_encode(list[i], ok);
            if (ok) begin
                exp_addr.push_back(32'(a));
                exp_data.push_back(w);
                a = a + 10'd1;
                legal++;
            end else if (!any_bad) begin
                any_bad = 1'b1;
                first_bad = a;
            end
        end
        start_job(base, 10'(legal));
        rand_ready = 1'b1;
        foreach (list[i]) applyStimulus(list[i]);
        wait_idle();
        rand_ready = 1'b0;
        compare_writes("rand");
        checkOutput("rand_err_illegal", 32'(err_illegal), 32'(any_bad));
        if (any_bad) checkOutput("rand_err_addr", 32'(err_addr), 32'(first_bad));
    endtask

    initial begin
        req_t        r;
        bit          ok;
        logic [31:0] w;
        logic [9:0]  snap_addr;
        logic [31:0] snap_data;
        int          done0;

        n_checks = 0; n_pass = 0; done_cnt = 0;
        rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0;
        req_valid = 1'b0; req_class = '0; req_funct3 = '0; req_alt = 1'b0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        ready_force = 1'b0; rand_ready = 1'b0;

        vecs[0]  = '{mk(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0),           32'h002081B3};
        vecs[1]  = '{mk(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0),           32'h402081B3};
        vecs[2]  = '{mk(3'd1, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd7),           32'h40735293};
        vecs[3]  = '{mk(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC),   32'hFE208EE3};
        vecs[4]  = '{mk(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048),        32'h001000EF};
        vecs[5]  = '{mk(3'd2, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFF),   32'hFFF12283};
        vecs[6]  = '{mk(3'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8),           32'h00512423};
        vecs[7]  = '{mk(3'd5, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5000),   32'h123453B7};
        vecs[8]  = '{mk(3'd7, 3'd0, 1'b0, 5'd1, 5'd5, 5'd0, 32'hFFFF_FFF8),   32'hFF8280E7};
        vecs[9]  = '{mk(3'd1, 3'd6, 1'b0, 5'd4, 5'd4, 5'd0, 32'd2047),        32'h7FF26213};
        vecs[10] = '{mk(3'd1, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0, 32'd31),          32'h01F11093};
        vecs[11] = '{mk(3'd4, 3'd1, 1'b0, 5'd0, 5'd3, 5'd4, 32'd4094),        32'h7E419FE3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err_illegal", 32'(err_illegal), 32'd0);
        checkOutput("rst_err_addr", 32'(err_addr), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_force = 1'b1;

        // ADD / SUB / SRAI back-to-back, single done pulse
        done0 = done_cnt;
        start_job(10'h010, 10'd3);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i].req);
            exp_addr.push_back(32'h010 + 32'(i));
            exp_data.push_back(vecs[i].word);
        end
        wait_idle();
        compare_writes("basic");
        checkOutput("basic_done_pulses", 32'(done_cnt - done0), 32'd1);

        // Remaining encoding vectors
        start_job(10'h100, 10'd9);
        for (int i = 3; i < 12; i++) begin
            applyStimulus(vecs[i].req);
            exp_addr.push_back(32'h100 + 32'(i - 3));
            exp_data.push_back(vecs[i].word);
        end
        wait_idle();
        compare_writes("vec");

        // Illegal request is swallowed, then the legal one lands at base
        start_job(10'h040, 10'd1);
        applyStimulus(mk(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048));
        applyStimulus(mk(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1));
        exp_addr.push_back(32'h040);
        exp_data.push_back(32'h00100093);
        wait_idle();
        compare_writes("illegal");
        checkOutput("illegal_err_flag", 32'(err_illegal), 32'd1);
        checkOutput("illegal_err_addr", 32'(err_addr), 32'h040);

        // Address wrap, plus two-edge latency of the first word
        start_job(10'h3FF, 10'd2);
        checkOutput("start_clears_err", 32'(err_illegal), 32'd0);
        applyStimulus(mk(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd5));
        @(negedge clk);
        checkOutput("latency_we_early", 32'(mem_we), 32'd0);
        @(negedge clk);
        checkOutput("latency_we_on_time", 32'(mem_we), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(mk(3'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd6));
        exp_addr.push_back(32'h3FF);
        exp_data.push_back(32'h00500113);
        exp_addr.push_back(32'h000);
        exp_data.push_back(32'h00600193);
        wait_idle();
        compare_writes("wrap");

        // Backpressure: mem_ready low for 5 cycles mid-stream
        start_job(10'h020, 10'd6);
        for (int i = 0; i < 6; i++) begin
            w = model_encode(mk(3'd1, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i * 3 + 1)), ok);
            exp_addr.push_back(32'h020 + 32'(i));
            exp_data.push_back(w);
        end
        fork
            begin : bp_send
                for (int i = 0; i < 6; i++)
                    applyStimulus(mk(3'd1, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i * 3 + 1)));
            end
            begin : bp_ctrl
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!mem_we && n < 100);
                @(posedge clk);
                #1;
                ready_force = 1'b0;
                @(negedge clk);
                snap_addr = mem_addr;
                snap_data = mem_wdata;
                checkOutput("bp_we_held", 32'(mem_we), 32'd1);
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("bp_addr_stable", 32'(mem_addr), 32'(snap_addr));
                    checkOutput("bp_data_stable", mem_wdata, snap_data);
                end
                checkOutput("bp_req_ready_low", 32'(req_ready), 32'd0);
                @(posedge clk);
                #1;
                ready_force = 1'b1;
            end
        join
        wait_idle();
        compare_writes("bp");

        // Reset with S1 and S2 both occupied and memory stalled
        start_job(10'h050, 10'd4);
        ready_force = 1'b0;
        applyStimulus(mk(3'd3, 3'd3, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0));
        applyStimulus(mk(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd9));
        applyStimulus(mk(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd10));
        @(negedge clk);
        checkOutput("pre_rst_we", 32'(mem_we), 32'd1);
        checkOutput("pre_rst_err", 32'(err_illegal), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        cfg_base = 10'h111;
        cfg_len = 10'd2;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        ready_force = 1'b1;
        @(negedge clk);
        checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_err", 32'(err_illegal), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("midrst_no_writes", 32'(wr_data.size()), 32'd0);
        wr_addr.delete(); wr_data.delete();
        @(posedge clk);
        #1;

        for (int j = 0; j < 4; j++) run_random_job(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got running, want finished");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder/loader: the inverse of the core's instruction decoder. It accepts field-level instruction requests (class, funct3, alt bit, registers, immediate) over a valid/ready handshake. It packs them into legal 32-bit RV32I words, range-checks the immediates, and writes the words into instruction memory at consecutive word addresses. It sits in the test/boot path in front of the instruction memory write port.

## Interface
- ADDR_W, 10: instruction-memory word-address width
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE and loads cfg_base/cfg_len
- cfg_base  in  ADDR_W  first word address
- cfg_len  in  ADDR_W  number of legal words to write; must be ≥1
- req_valid / req_ready  in / out  1  request handshake
- req_class  in  3  0 R, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 JAL, 7 JALR
- req_funct3  in  3  funct3 field
- req_alt  in  1  selects funct7=0100000 (SUB/SRA/SRAI)
- req_rd, req_rs1, req_rs2  in  5 each  register fields
- req_imm  in  32  byte offset or value, sign-extended
- mem_we  out  1  write valid
- mem_ready  in  1  memory accepts the write
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when cfg_len words have been written
- err_illegal  out  1  sticky; cleared only by rst or start
- err_addr  out  ADDR_W  write address current when the first illegal request was consumed

## Operation
- FSM: IDLE → RUN on start. RUN → DRAIN when the accepted-legal count reaches cfg_len. DRAIN → IDLE once the final write handshakes; done pulses in that cycle. start outside IDLE is ignored.
- Pipeline: S1 is a request register, S2 is the output register (mem_we/addr/wdata). Encoding and the legality check are combinational from S1 to S2.
- req_ready = (state==RUN) && accepted-legal count < cfg_len && (!S1 full || S1 advances). S1 advances when S2 is empty or (mem_we && mem_ready).
- Encodings:
  - R: {f7,rs2,rs1,f3,rd,0110011}, f7 = alt ? 0100000 : 0.
  - OP-IMM 0010011: for f3 001/101, {f7,imm[4:0],rs1,f3,rd,op}; otherwise {imm[11:0],rs1,f3,rd,op}.
  - LOAD 0000011: {imm[11:0],rs1,f3,rd,op}.
  - STORE 0100011: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - BRANCH 1100011: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - LUI 0110111: {imm[31:12],rd,op}.
  - JAL 1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
  - JALR 1100111: {imm[11:0],rs1,000,rd,op}.
- Illegal if any of:
  - R: alt set with f3 ∉ {000,101}.
  - OP-IMM: alt set with f3 ≠ 101. For shifts, imm[31:5] ≠ 0. For other f3, imm[31:11] not all equal.
  - LOAD: f3 ∉ {000,001,010,100,101}.
  - STORE: f3 > 010.
  - BRANCH: f3 ∈ {010,011}.
  - JALR: f3 ≠ 000.
  - LOAD/STORE/JALR: imm[31:11] not uniform.
  - BRANCH: imm[31:12] not uniform or imm[0] set.
  - JAL: imm[31:20] not uniform or imm[0] set.
  - LUI: imm[11:0] ≠ 0.
- Illegal request handling: it is consumed and produces no write. It does not advance the address or the count. It sets err_illegal; err_addr is captured only on the first one.
- Address: starts at cfg_base and increments by 1 per legal write. It wraps modulo 2^ADDR_W.

## Timing
- Reset values: state IDLE, S1/S2 empty, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err_illegal 0, err_addr 0, counters 0.
- Latency: a request accepted at edge N produces mem_we at edge N+2 (S1 at N, S2 at N+1 edge → visible after N+1… registered, mem_we high from cycle N+2).
- Throughput: 1 word/cycle while mem_ready is held high.
- While mem_we && !mem_ready, mem_addr and mem_wdata stay stable. At most one further request is accepted (into S1).
- A legal request arriving in the same cycle S2 drains is accepted with no bubble.
- rst mid-operation: returns to the reset state in the next cycle and drops any in-flight words. A write already handshaken stays written.
- start in the same cycle as rst: rst wins.

## Test plan
- start with base 0x010, len 3. Send ADD x3,x1,x2; SUB x3,x1,x2; SRAI x5,x6,7 back-to-back with mem_ready=1. Required: writes 0x002081B3@0x010, 0x402081B3@0x011, 0x40735293@0x012; done pulses once; busy then falls.
- Branch/jump: BEQ x1,x2,imm=-4 → 0xFE208EE3. JAL x1,imm=2048 → 0x001000EF. LW x5,-1(x2) → 0xFFF12283. SW x5,8(x2) → 0x00512423.
- Illegal: ADDI imm=2048, then ADDI x1,x0,1 with len 1. Required: no write for the first request; err_illegal=1 and err_addr=base; second request written as 0x00100093 at base.
- Backpressure: hold mem_ready=0 for 5 cycles mid-stream. Required: mem_addr/mem_wdata stable, req_ready low after S1 fills, no word lost or duplicated, order preserved.
- Wrap: ADDR_W=10, base 0x3FF, len 2. Required: writes go to 0x3FF then 0x000.
- Reset while S1 and S2 are both full and mem_ready=0. Required: the next cycle shows mem_we=0, busy=0, err_illegal=0, and no further writes.
